a23_out_fifo_resp: RTL

- Memory-mapped responder on the a23 core data bus (address / write data / write enable / byte enable in, read data out).
- Converts core stores to a fixed window into a ready/valid output word stream.
- Sits beside a23_mem on the same bus; its output is muxed in by address at the top level.
- Lets a garbled program emit results incrementally instead of only through the output memory region.

---
 rtl/a23_resp_pkg.sv | 26 ++
 rtl/a23_sync_fifo.sv | 66 ++++++
 rtl/a23_out_fifo_resp.sv | 109 ++++++++++
 3 files changed

// File: rtl/a23_resp_pkg.sv
// Shared register map and bit positions for the a23 output-FIFO responder.
package a23_resp_pkg;

   localparam logic [1:0] OFF_DATA   = 2'd0;
   localparam logic [1:0] OFF_STATUS = 2'd1;
   localparam logic [1:0] OFF_CTRL   = 2'd2;
   localparam logic [1:0] OFF_DROP   = 2'd3;

   localparam int unsigned ST_EMPTY = 16;
   localparam int unsigned ST_FULL  = 17;
   localparam int unsigned ST_OVF   = 18;

   localparam int unsigned CTRL_CLR   = 0;
   localparam int unsigned CTRL_FLUSH = 1;

   // Zero every byte lane whose enable bit is clear.
   function automatic logic [31:0] lane_mask(input logic [31:0] data,
                                             input logic [3:0]  be);
      logic [31:0] res;
      res = '0;
      for (int unsigned i = 0; i < 4; i++)
         if (be[i]) res[i*8 +: 8] = data[i*8 +: 8];
      return res;
   endfunction

endpackage

// File: rtl/a23_sync_fifo.sv
// Synchronous word FIFO with flush; head word is forced to zero while empty.
module a23_sync_fifo #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  logic [31:0]      din,
   output logic [31:0]      dout,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [0:0] MODE_NORMAL = 1'b0;
   localparam logic [0:0] MODE_FLUSH  = 1'b1;

   logic [31:0]   mem [DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic [0:0]    mode;
   logic          do_push;
   logic          do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CNT_W'(DEPTH));
   assign do_pop  = pop && !empty;
   // A pop frees the slot the push needs, so a full FIFO still accepts.
   assign do_push = push && (!full || do_pop);
   assign mode    = flush ? MODE_FLUSH : MODE_NORMAL;
   assign dout    = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         case (mode)
            MODE_FLUSH: begin
               rd_ptr <= '0;
               wr_ptr <= '0;
               count  <= '0;
            end
            default: begin
               if (do_push) wr_ptr <= wr_ptr + AW'(1);
               if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
               if (do_push && !do_pop)
                  count <= count + CNT_W'(1);
               else if (!do_push && do_pop)
                  count <= count - CNT_W'(1);
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && mode == MODE_NORMAL && do_push)
         mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/a23_out_fifo_resp.sv
// a23 data-bus responder turning stores to DATA into a ready/valid word stream.
// Optional saturating drop counter at offset 0xC: A23_OUT_FIFO_DROP_CNT_EN.
module a23_out_fifo_resp
   import a23_resp_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h05000000,
   parameter int unsigned DEPTH     = 8,
   parameter int unsigned CNT_W     = $clog2(DEPTH) + 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] i_m_address,
   input  logic [31:0] i_m_write,
   input  logic        i_m_write_en,
   input  logic [3:0]  i_m_byte_enable,
   output logic [31:0] o_m_read,
   output logic        o_sel,
   output logic        o_valid,
   output logic [31:0] o_data,
   input  logic        i_ready
);

   logic [1:0]       offset;
   logic [31:0]      wdata;
   logic             wr_hit;
   logic             push_req;
   logic             ctrl_wr;
   logic             clr;
   logic             flush;
   logic             pop;
   logic             drop;
   logic             overflow;
   logic             full;
   logic             empty;
   logic [CNT_W-1:0] count;
   logic [31:0]      status;
   logic [31:0]      drop_rd;
   logic             unused_addr;

   assign unused_addr = ^{i_m_address[23:4], i_m_address[1:0]};

   assign o_sel    = (i_m_address[31:24] == BASE_ADDR[31:24]);
   assign offset   = i_m_address[3:2];
   assign wdata    = lane_mask(i_m_write, i_m_byte_enable);
   assign wr_hit   = o_sel && i_m_write_en && (i_m_byte_enable != 4'h0);
   assign push_req = wr_hit && (offset == OFF_DATA);
   assign ctrl_wr  = wr_hit && (offset == OFF_CTRL);
   assign clr      = ctrl_wr && wdata[CTRL_CLR];
   assign flush    = ctrl_wr && wdata[CTRL_FLUSH];
   assign pop      = o_valid && i_ready;
   assign drop     = push_req && full && !pop;
   assign o_valid  = !empty;

   a23_sync_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push_req),
      .pop   (pop),
      .flush (flush),
      .din   (wdata),
      .dout  (o_data),
      .count (count),
      .full  (full),
      .empty (empty)
   );

   always_ff @(posedge clk) begin
      if (rst)       overflow <= 1'b0;
      else if (drop) overflow <= 1'b1;
      else if (clr)  overflow <= 1'b0;
   end

`ifdef A23_OUT_FIFO_DROP_CNT_EN
   logic [15:0] drop_cnt;

   always_ff @(posedge clk) begin
      if (rst)
         drop_cnt <= '0;
      else if (drop) begin
         if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      end else if (clr)
         drop_cnt <= '0;
   end

   assign drop_rd = {16'h0000, drop_cnt};
`else
   assign drop_rd = '0;
`endif

   always_comb begin
      status                = '0;
      status[CNT_W-1:0]     = count;
      status[ST_EMPTY]      = empty;
      status[ST_FULL]       = full;
      status[ST_OVF]        = overflow;
   end

   always_comb begin
      o_m_read = '0;
      if (o_sel) begin
         case (offset)
            OFF_STATUS: o_m_read = status;
            OFF_DROP:   o_m_read = drop_rd;
            default:    o_m_read = '0;
         endcase
      end
   end

endmodule
